// File: rtl/display_scheduler.sv
// Arbitrates the shared 3-bit LED display between the dice and traffic-light blocks.
// Owns the mux select, gates roll/advance enables, and times the dice result hold.
module display_scheduler #(
  parameter int HOLD_CYCLES  = 8,
  parameter int LIGHT_PERIOD = 4,
  parameter int MIN_LIGHT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] throw,
  input  logic [2:0] tl,
  output logic       dice_en,
  output logic       light_en,
  output logic       sel,
  output logic       busy,
  output logic [2:0] result
);

  localparam logic [1:0] S_LIGHTS = 2'd0;
  localparam logic [1:0] S_ROLL   = 2'd1;
  localparam logic [1:0] S_SHOW   = 2'd2;

  localparam logic [7:0] PRESC_LAST = 8'(LIGHT_PERIOD - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GUARD_LOAD = 8'(MIN_LIGHT);

  logic [1:0] state_reg, state_next;
  logic [7:0] presc_reg, presc_next;
  logic [7:0] guard_reg, guard_next;
  logic [7:0] hold_reg, hold_next;
  logic [2:0] show_val_reg, show_val_next;
  logic [2:0] result_reg, result_next;
  logic       presc_wrap;

  always_comb begin
    presc_wrap = (state_reg == S_LIGHTS) && (presc_reg == PRESC_LAST);
  end

  assign busy     = (state_reg == S_ROLL) || (state_reg == S_SHOW);
  assign sel      = !busy;
  assign dice_en  = (state_reg == S_ROLL);
  assign light_en = presc_wrap;
  assign result   = result_reg;

  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    guard_next    = guard_reg;
    hold_next     = hold_reg;
    show_val_next = show_val_reg;
    result_next   = tl;
    case (state_reg)
      S_LIGHTS: begin
        presc_next = presc_wrap ? 8'd0 : presc_reg + 8'd1;
        guard_next = (guard_reg == 8'd0) ? 8'd0 : guard_reg - 8'd1;
        // The wrap strobe still fires on the grant edge; presc freezes afterwards.
        if (button && (guard_reg == 8'd0)) begin
          state_next = S_ROLL;
        end
      end
      S_ROLL: begin
        result_next = throw;
        if (!button) begin
          show_val_next = throw;
          hold_next     = HOLD_LOAD;
          state_next    = S_SHOW;
        end
      end
      S_SHOW: begin
        result_next = show_val_reg;
        if (hold_reg == 8'd0) begin
          guard_next = GUARD_LOAD;
          state_next = S_LIGHTS;
        end else begin
          hold_next = hold_reg - 8'd1;
        end
      end
      default: begin
        state_next = S_LIGHTS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_LIGHTS;
      presc_reg    <= 8'd0;
      guard_reg    <= 8'd0;
      hold_reg     <= 8'd0;
      show_val_reg <= 3'd0;
      result_reg   <= 3'd0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      guard_reg    <= guard_next;
      hold_reg     <= hold_next;
      show_val_reg <= show_val_next;
      result_reg   <= result_next;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: two parameterisations driven by shared random stimulus,
// checked every cycle against a cycle-count model, plus directed literal checks.
module tb_display_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] throw_v;
  logic [2:0] tl_v;
  logic [1:0] dice_en, light_en, sel, busy;
  logic [2:0] res [2];

  always #5 clk = ~clk;

  display_scheduler u0 (
    .clk(clk), .rst(rst), .button(button), .throw(throw_v), .tl(tl_v),
    .dice_en(dice_en[0]), .light_en(light_en[0]), .sel(sel[0]), .busy(busy[0]),
    .result(res[0])
  );

  display_scheduler #(.HOLD_CYCLES(1), .LIGHT_PERIOD(1), .MIN_LIGHT(0)) u1 (
    .clk(clk), .rst(rst), .button(button), .throw(throw_v), .tl(tl_v),
    .dice_en(dice_en[1]), .light_en(light_en[1]), .sel(sel[1]), .busy(busy[1]),
    .result(res[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  int p_hold [2] = '{8, 1};
  int p_per  [2] = '{4, 1};
  int p_min  [2] = '{2, 0};

  // Model: mode 0 = display on lights, 1 = rolling, 2 = showing a result.
  int         m_mode   [2];
  int         m_lights [2];  // LIGHTS cycles completed since reset
  int         m_since  [2];  // LIGHTS cycles completed since last SHOW ended
  int         m_left   [2];  // SHOW cycles still to go, including current
  logic [2:0] m_shown  [2];
  logic [2:0] m_res    [2];
  bit         m_valid = 1'b0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        m_mode[d]   = 0;
        m_lights[d] = 0;
        m_since[d]  = p_min[d];
        m_left[d]   = 0;
        m_shown[d]  = 3'd0;
        m_res[d]    = 3'd0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] nr;
        bit         grant;
        nr = (m_mode[d] == 0) ? tl_v : (m_mode[d] == 1) ? throw_v : m_shown[d];
        case (m_mode[d])
          0: begin
            grant = button && (m_since[d] >= p_min[d]);
            m_lights[d]++;
            m_since[d]++;
            if (grant) m_mode[d] = 1;
          end
          1: begin
            if (!button) begin
              m_shown[d] = throw_v;
              m_left[d]  = p_hold[d];
              m_mode[d]  = 2;
            end
          end
          default: begin
            m_left[d]--;
            if (m_left[d] == 0) begin
              m_mode[d]  = 0;
              m_since[d] = 0;
            end
          end
        endcase
        m_res[d] = nr;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        check("sel", d, 32'(sel[d]), 32'(m_mode[d] == 0));
        check("dice_en", d, 32'(dice_en[d]), 32'(m_mode[d] == 1));
        check("busy", d, 32'(busy[d]), 32'(m_mode[d] != 0));
        check("light_en", d, 32'(light_en[d]),
              32'((m_mode[d] == 0) && ((m_lights[d] % p_per[d]) == p_per[d] - 1)));
        check("result", d, 32'(res[d]), 32'(m_res[d]));
      end
    end
  end

  initial begin
    int dcnt, show5, ret, b1, d1, s1, l1, run;
    rst = 1'b0; button = 1'b0; throw_v = 3'd0; tl_v = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rst_sel", 0, 32'(sel[0]), 32'd1);
    check("rst_result", 0, 32'(res[0]), 32'd0);
    check("rst_busy", 0, 32'(busy[0]), 32'd0);
    $display("txn reset: sel=%0b result=%0d busy=%0b", sel[0], res[0], busy[0]);

    for (int i = 1; i <= 12; i++) begin
      check("light_period", 0, 32'(light_en[0]), 32'((i % 4) == 0));
      @(negedge clk);
      tl_v = 3'($urandom_range(0, 7));
    end
    $display("txn light_period: 12 LIGHTS cycles observed");

    // Five ROLL cycles, release with throw=5 on the last ROLL edge.
    tl_v = 3'd0; throw_v = 3'd2; button = 1'b1;
    dcnt = 0;
    repeat (5) begin
      @(negedge clk);
      dcnt += int'(dice_en[0]);
    end
    button = 1'b0; throw_v = 3'd5;
    show5 = 0; ret = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      throw_v = 3'd3;
      dcnt += int'(dice_en[0]);
      if (busy[0] && !dice_en[0] && res[0] == 3'd5) show5++;
      if (sel[0]) begin
        ret = k;
        break;
      end
    end
    check("roll_cycles", 0, 32'(dcnt), 32'd5);
    check("show_cycles", 0, 32'(show5), 32'd8);
    check("sel_return", 0, 32'(ret), 32'd9);
    $display("txn roll: dice_en=%0d show=%0d sel_back_after=%0d", dcnt, show5, ret);

    // presc was 1 when ROLL began, so the next strobe is the 3rd LIGHTS cycle.
    for (int c = 1; c <= 3; c++) begin
      check("presc_freeze", 0, 32'(light_en[0]), 32'(c == 3));
      @(negedge clk);
    end
    $display("txn presc_freeze: strobe on LIGHTS cycle 3");

    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midshow_sel", 0, 32'(sel[0]), 32'd1);
    check("midshow_busy", 0, 32'(busy[0]), 32'd0);
    check("midshow_result", 0, 32'(res[0]), 32'd0);
    button = 1'b1;
    @(negedge clk);
    check("regrant", 0, 32'(dice_en[0]), 32'd1);
    button = 1'b0;
    $display("txn midshow_reset: regrant dice_en=%0b", dice_en[0]);
    repeat (14) @(negedge clk);

    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    b1 = 0; d1 = 0; s1 = 0; l1 = 0;
    for (int k = 0; k < 10; k++) begin
      b1 += int'(busy[1]);
      d1 += int'(dice_en[1]);
      if (sel[1]) begin
        s1++;
        l1 += int'(light_en[1]);
      end
      @(negedge clk);
    end
    check("fast_roll", 1, 32'(d1), 32'd1);
    check("fast_busy", 1, 32'(b1), 32'd2);
    check("fast_lights", 1, 32'(s1), 32'd8);
    check("fast_strobes", 1, 32'(l1), 32'd8);
    $display("txn fast_pulse: roll=%0d busy=%0d strobes=%0d", d1, b1, l1);

    run = 0;
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        tl_v    = 3'($urandom_range(0, 7));
        throw_v = 3'($urandom_range(0, 7));
        if (run == 0) begin
          button = 1'($urandom_range(0, 1));
          run    = int'($urandom_range(1, 12));
        end
        run--;
        rst = ($urandom_range(0, 199) != 0);
      end
      $display("txn random block %0d: compared so far %0d", blk, n_cmp);
    end
    rst = 1'b1; button = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
